// File: rtl/cnn_job_scheduler.sv
// Job dispatcher for a pool of convolution cores: FIFO intake, round-robin
// dispatch, per-core start/done/recycle tracking and a one-entry completion reg.
module cnn_job_scheduler #(
  parameter int NUM_CORES   = 4,
  parameter int JOB_ID_W    = 8,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          job_valid,
  input  logic [JOB_ID_W-1:0]           job_id,
  output logic                          job_ready,
  input  logic                          pause,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [NUM_CORES-1:0]          core_rst,
  input  logic [NUM_CORES-1:0]          core_done,
  output logic [NUM_CORES*JOB_ID_W-1:0] core_job_id,
  output logic                          cmp_valid,
  output logic [JOB_ID_W-1:0]           cmp_job_id,
  output logic [2:0]                    cmp_core,
  input  logic                          cmp_ready,
  output logic [3:0]                    busy_count,
  output logic [15:0]                   jobs_done,
  output logic                          idle
);

  localparam int AW  = $clog2(QUEUE_DEPTH);
  localparam int CW  = AW + 1;
  localparam int PW  = $clog2(NUM_CORES);
  localparam int PW1 = PW + 1;

  typedef enum logic [1:0] {
    FREE,
    RUN,
    PEND,
    RECYCLE
  } core_st_e;

  core_st_e            st_q [NUM_CORES];
  core_st_e            st_d [NUM_CORES];
  logic [JOB_ID_W-1:0] jid_q [NUM_CORES];
  logic [JOB_ID_W-1:0] fifo_mem [QUEUE_DEPTH];

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        fifo_cnt;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 cmp_take;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        disp_sel;
  logic [PW-1:0]        pick_sel;
  logic [PW-1:0]        cand;
  logic [PW1-1:0]       cand_wide;
  logic                 free_found;
  logic                 disp_en;
  logic                 pend_found;
  logic                 pick_en;
  logic                 all_free;
  logic [NUM_CORES-1:0] start_d;
  logic [NUM_CORES-1:0] rst_d;
  logic [3:0]           busy_d;
  logic [15:0]          jobs_done_q;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CW'(QUEUE_DEPTH));
  assign job_ready  = !fifo_full;
  assign push       = job_valid && job_ready;
  assign cmp_take   = cmp_valid && cmp_ready;
  assign jobs_done  = jobs_done_q;
  assign idle       = fifo_empty && all_free && !cmp_valid;

  always_comb begin
    all_free = 1'b1;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (st_q[k] != FREE) all_free = 1'b0;
    end
  end

  // Round-robin search starts one past the last core served.
  always_comb begin
    free_found = 1'b0;
    disp_sel   = '0;
    cand_wide  = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      cand_wide = {1'b0, rr_ptr} + PW1'(i);
      if (cand_wide >= PW1'(NUM_CORES))
        cand_wide = cand_wide - PW1'(NUM_CORES);
      cand = cand_wide[PW-1:0];
      if (!free_found && st_q[cand] == FREE) begin
        free_found = 1'b1;
        disp_sel   = cand;
      end
    end
    disp_en = free_found && !fifo_empty && !pause;
  end

  always_comb begin
    pend_found = 1'b0;
    pick_sel   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!pend_found && st_q[k] == PEND) begin
        pend_found = 1'b1;
        pick_sel   = PW'(k);
      end
    end
    pick_en = pend_found && (!cmp_valid || cmp_ready);
  end

  always_comb begin
    busy_d = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      st_d[k]    = st_q[k];
      start_d[k] = disp_en && (disp_sel == PW'(k));
      unique case (st_q[k])
        FREE:    if (start_d[k]) st_d[k] = RUN;
        RUN:     if (core_done[k] && !core_start[k]) st_d[k] = PEND;
        PEND:    if (pick_en && pick_sel == PW'(k)) st_d[k] = RECYCLE;
        RECYCLE: st_d[k] = FREE;
        default: st_d[k] = FREE;
      endcase
      rst_d[k] = (st_d[k] == RECYCLE);
      if (st_d[k] != FREE) busy_d = busy_d + 4'd1;
    end
  end

  always_comb begin
    core_job_id = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      core_job_id[k*JOB_ID_W +: JOB_ID_W] = jid_q[k];
    end
  end

  // Storage only; occupancy and pointers carry the reset state.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= job_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (disp_en) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, disp_en})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        st_q[k]  <= FREE;
        jid_q[k] <= '0;
      end
      rr_ptr     <= PW'(NUM_CORES - 1);
      core_start <= '0;
      core_rst   <= '0;
      busy_count <= '0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        st_q[k] <= st_d[k];
      end
      core_start <= start_d;
      core_rst   <= rst_d;
      busy_count <= busy_d;
      if (disp_en) begin
        jid_q[disp_sel] <= fifo_mem[rd_ptr];
        rr_ptr          <= disp_sel;
      end
    end
  end

  // A PEND core is never the dispatch target, so its id is stable here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid   <= 1'b0;
      cmp_job_id  <= '0;
      cmp_core    <= '0;
      jobs_done_q <= '0;
    end else begin
      if (pick_en) begin
        cmp_valid  <= 1'b1;
        cmp_job_id <= jid_q[pick_sel];
        cmp_core   <= 3'(pick_sel);
      end else if (cmp_take) begin
        cmp_valid <= 1'b0;
      end
      if (cmp_take) jobs_done_q <= jobs_done_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_cnn_job_scheduler.sv
// Bench for cnn_job_scheduler: queue/array reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_cnn_job_scheduler;

  localparam int NC = 4;
  localparam int W  = 8;
  localparam int QD = 4;

  logic            clk;
  logic            rst;
  logic            job_valid;
  logic [W-1:0]    job_id;
  logic            job_ready;
  logic            pause;
  logic [NC-1:0]   core_start;
  logic [NC-1:0]   core_rst;
  logic [NC-1:0]   core_done;
  logic [NC*W-1:0] core_job_id;
  logic            cmp_valid;
  logic [W-1:0]    cmp_job_id;
  logic [2:0]      cmp_core;
  logic            cmp_ready;
  logic [3:0]      busy_count;
  logic [15:0]     jobs_done;
  logic            idle;

  cnn_job_scheduler #(
    .NUM_CORES(NC),
    .JOB_ID_W(W),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .job_valid(job_valid),
    .job_id(job_id),
    .job_ready(job_ready),
    .pause(pause),
    .core_start(core_start),
    .core_rst(core_rst),
    .core_done(core_done),
    .core_job_id(core_job_id),
    .cmp_valid(cmp_valid),
    .cmp_job_id(cmp_job_id),
    .cmp_core(cmp_core),
    .cmp_ready(cmp_ready),
    .busy_count(busy_count),
    .jobs_done(jobs_done),
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: spec-level core status per index plus a job queue.
  logic [W-1:0] mq[$];
  int           mst [NC];
  logic [NC-1:0] m_start;
  logic [NC-1:0] m_rst;
  logic [W-1:0] m_jid [NC];
  logic         m_cv;
  logic [W-1:0] m_cid;
  logic [2:0]   m_cc;
  int           m_rr;
  logic [15:0]  m_jd;

  task automatic mreset();
    mq.delete();
    for (int k = 0; k < NC; k++) begin
      mst[k] = 0;
      m_jid[k] = '0;
    end
    m_start = '0;
    m_rst = '0;
    m_cv = 1'b0;
    m_cid = '0;
    m_cc = '0;
    m_rr = NC - 1;
    m_jd = '0;
  endtask

  task automatic madvance();
    int nst [NC];
    int sel;
    int pick;
    bit full;
    bit pu;
    full = (mq.size() == QD);
    pu = job_valid && !full;
    sel = -1;
    if (mq.size() > 0 && !pause)
      for (int i = 1; i <= NC; i++)
        if (sel < 0 && mst[(m_rr + i) % NC] == 0) sel = (m_rr + i) % NC;
    pick = -1;
    if (!m_cv || cmp_ready)
      for (int k = 0; k < NC; k++)
        if (pick < 0 && mst[k] == 2) pick = k;
    if (m_cv && cmp_ready) m_jd = m_jd + 16'd1;
    for (int k = 0; k < NC; k++) begin
      nst[k] = mst[k];
      case (mst[k])
        0: if (sel == k) nst[k] = 1;
        1: if (core_done[k] && !m_start[k]) nst[k] = 2;
        2: if (pick == k) nst[k] = 3;
        default: nst[k] = 0;
      endcase
    end
    m_start = '0;
    if (sel >= 0) begin
      m_start[sel] = 1'b1;
      m_jid[sel] = mq.pop_front();
      m_rr = sel;
    end
    if (pu) mq.push_back(job_id);
    if (pick >= 0) begin
      m_cv = 1'b1;
      m_cid = m_jid[pick];
      m_cc = 3'(pick);
    end else if (m_cv && cmp_ready) begin
      m_cv = 1'b0;
    end
    for (int k = 0; k < NC; k++) begin
      m_rst[k] = (nst[k] == 3);
      mst[k] = nst[k];
    end
  endtask

  always @(posedge clk) begin
    if (rst) mreset();
    else madvance();
  end

  always @(negedge clk) begin
    if (!rst) begin
      int nb;
      bit allf;
      nb = 0;
      allf = 1'b1;
      for (int k = 0; k < NC; k++)
        if (mst[k] != 0) begin
          nb++;
          allf = 1'b0;
        end
      chk("job_ready", job_ready, mq.size() != QD);
      chk("core_start", core_start, m_start);
      chk("core_rst", core_rst, m_rst);
      chk("core_job_id", core_job_id, {m_jid[3], m_jid[2], m_jid[1], m_jid[0]});
      chk("cmp_valid", cmp_valid, m_cv);
      chk("cmp_job_id", cmp_job_id, m_cid);
      chk("cmp_core", cmp_core, m_cc);
      chk("busy_count", busy_count, nb);
      chk("jobs_done", jobs_done, m_jd);
      chk("idle", idle, mq.size() == 0 && allf && !m_cv);
    end
  end

  // Behavioural cores: done rises dur cycles after start, cleared by core_rst.
  int dur [NC];
  int tmr [NC];
  logic [NC-1:0] done_r;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < NC; k++) begin
        if (rst || m_rst[k]) begin
          done_r[k] = 1'b0;
          tmr[k] = 0;
        end else if (m_start[k] && dur[k] > 0) begin
          tmr[k] = dur[k];
        end else if (tmr[k] > 0) begin
          tmr[k]--;
          if (tmr[k] == 0) done_r[k] = 1'b1;
        end
      end
      core_done = done_r;
    end
  endtask

  task automatic set_done(input logic [NC-1:0] m);
    done_r = done_r | m;
    core_done = done_r;
  endtask

  task automatic do_reset();
    job_valid = 1'b0;
    pause = 1'b0;
    cmp_ready = 1'b1;
    for (int k = 0; k < NC; k++) dur[k] = 0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_cmp(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (cmp_valid) break;
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    job_valid = 1'b0;
    job_id = '0;
    pause = 1'b0;
    cmp_ready = 1'b1;
    core_done = '0;
    done_r = '0;
    for (int k = 0; k < NC; k++) begin
      dur[k] = 0;
      tmr[k] = 0;
    end
    tick(3);
    rst = 1'b0;
    chk("reset idle", idle, 1);
    chk("reset job_ready", job_ready, 1);
    chk("reset busy", busy_count, 0);
    chk("reset jobs_done", jobs_done, 0);

    // Single job through core 0
    dur[0] = 20;
    job_valid = 1'b1;
    job_id = 8'h11;
    tick();
    job_valid = 1'b0;
    chk("single no start yet", core_start, 4'b0000);
    tick();
    chk("single start", core_start, 4'b0001);
    chk("single job id", core_job_id[7:0], 8'h11);
    chk("single busy", busy_count, 1);
    wait_cmp(60);
    chk("single cmp_valid", cmp_valid, 1);
    chk("single cmp_job_id", cmp_job_id, 8'h11);
    chk("single cmp_core", cmp_core, 0);
    chk("single core_rst", core_rst, 4'b0001);
    tick();
    chk("single jobs_done", jobs_done, 1);
    chk("single core_rst off", core_rst, 4'b0000);
    tick();
    chk("single idle", idle, 1);

    // Round robin over all cores, fifth job waits
    do_reset();
    job_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      job_id = W'(i);
      tick();
    end
    job_valid = 1'b0;
    chk("rr last start", core_start, 4'b1000);
    chk("rr ids", core_job_id, 32'h04030201);
    chk("rr busy", busy_count, 4);
    tick();
    chk("rr queued not idle", idle, 0);
    set_done(4'b0100);
    wait_cmp(10);
    chk("rr cmp id", cmp_job_id, 8'h03);
    chk("rr cmp core", cmp_core, 2);
    for (int i = 0; i < 10; i++) begin
      if (core_start != '0) break;
      tick();
    end
    chk("rr redispatch core", core_start, 4'b0100);
    chk("rr redispatch id", core_job_id[23:16], 8'h05);

    // Backpressure with pause
    do_reset();
    pause = 1'b1;
    job_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      job_id = 8'h21 + W'(i);
      tick();
    end
    chk("bp full", job_ready, 0);
    chk("bp paused busy", busy_count, 0);
    job_id = 8'h25;
    tick(2);
    chk("bp held", job_ready, 0);
    pause = 1'b0;
    tick();
    chk("bp reopen", job_ready, 1);
    chk("bp first start", core_start, 4'b0001);
    tick();
    job_valid = 1'b0;
    tick(4);
    chk("bp ids", core_job_id, 32'h24232221);
    chk("bp busy", busy_count, 4);
    chk("bp one queued", idle, 0);

    // Simultaneous done on cores 0 and 2 with completion backpressure
    do_reset();
    job_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      job_id = 8'h31 + W'(i);
      tick();
    end
    job_valid = 1'b0;
    tick(2);
    cmp_ready = 1'b0;
    set_done(4'b0101);
    tick(2);
    chk("sim c1 valid", cmp_valid, 1);
    chk("sim c1 core", cmp_core, 0);
    chk("sim c1 id", cmp_job_id, 8'h31);
    chk("sim c1 rst", core_rst, 4'b0001);
    tick();
    chk("sim c2 core", cmp_core, 0);
    chk("sim c2 rst", core_rst, 4'b0000);
    tick();
    chk("sim c3 id", cmp_job_id, 8'h31);
    cmp_ready = 1'b1;
    tick();
    chk("sim c4 core", cmp_core, 2);
    chk("sim c4 id", cmp_job_id, 8'h33);
    chk("sim c4 rst", core_rst, 4'b0100);
    chk("sim c4 jobs_done", jobs_done, 1);
    tick();
    chk("sim c5 valid", cmp_valid, 0);
    chk("sim c5 jobs_done", jobs_done, 2);

    // Reset in the middle of activity
    do_reset();
    job_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      job_id = 8'h41 + W'(i);
      tick();
    end
    job_valid = 1'b0;
    tick();
    pause = 1'b1;
    job_valid = 1'b1;
    job_id = 8'h44;
    tick();
    job_valid = 1'b0;
    tick();
    chk("mid busy", busy_count, 3);
    rst = 1'b1;
    #1;
    chk("mid rst busy", busy_count, 0);
    chk("mid rst ids", core_job_id, 0);
    chk("mid rst start", core_start, 0);
    chk("mid rst idle", idle, 1);
    tick(2);
    rst = 1'b0;
    pause = 1'b0;
    chk("mid rel idle", idle, 1);
    chk("mid rel ready", job_ready, 1);
    job_valid = 1'b1;
    job_id = 8'h45;
    tick();
    job_valid = 1'b0;
    tick();
    chk("mid next core", core_start, 4'b0001);
    chk("mid next id", core_job_id[7:0], 8'h45);

    // jobs_done wrap from a preloaded value
    do_reset();
    dur[0] = 3;
    dur[1] = 3;
    #2;
    force dut.jobs_done_q = 16'hFFFE;
    m_jd = 16'hFFFE;
    #1;
    release dut.jobs_done_q;
    tick();
    job_valid = 1'b1;
    job_id = 8'h51;
    tick();
    job_id = 8'h52;
    tick();
    job_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (jobs_done != 16'hFFFE) break;
      tick();
    end
    chk("wrap ffff", jobs_done, 16'hFFFF);
    for (int i = 0; i < 40; i++) begin
      if (jobs_done != 16'hFFFF) break;
      tick();
    end
    chk("wrap zero", jobs_done, 16'h0000);
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
